// File: rtl/alu_pkg.sv
// Shared ALU definitions: FSM state encoding, default datapath width and op encoding.
package alu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam int   ALU_WIDTH = 4;
    localparam logic OP_ADD    = 1'b0;
    localparam logic OP_SUB    = 1'b1;

endpackage

// File: rtl/full_adder.sv
// Existing 1-bit full adder cell used for every bit step of the serial engine.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial add/subtract engine, LSB first through one full_adder cell.
// Define SERIAL_ADD_FLAGS_EN to add the Z (zero) and V (signed overflow) outputs.
module serial_add_sub
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout
`ifdef SERIAL_ADD_FLAGS_EN
    ,
    output logic             Z,
    output logic             V
`endif
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_sr_q, a_sr_d;
    logic [WIDTH-1:0]   b_sr_q, b_sr_d;
    logic [WIDTH-1:0]   s_q, s_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               fa_sum, fa_cout;
    logic [WIDTH-1:0]   s_shift;
`ifdef SERIAL_ADD_FLAGS_EN
    logic               z_q, z_d;
    logic               v_q, v_d;
`endif

    full_adder u_full_adder (
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    assign s_shift = {fa_sum, s_q[WIDTH-1:1]};

    always_comb begin
        state_d     = state_q;
        a_sr_d      = a_sr_q;
        b_sr_d      = b_sr_q;
        s_d         = s_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        cout_d      = cout_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
`ifdef SERIAL_ADD_FLAGS_EN
        z_d         = z_q;
        v_d         = v_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    // Subtract is A + ~B + 1: invert B and seed the carry with 1.
                    a_sr_d     = A;
                    b_sr_d     = (sub == OP_SUB) ? ~B : B;
                    carry_d    = (sub == OP_SUB);
                    cnt_d      = '0;
                    s_d        = '0;
                    in_ready_d = 1'b0;
                    state_d    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                s_d     = s_shift;
                a_sr_d  = a_sr_q >> 1;
                b_sr_d  = b_sr_q >> 1;
                carry_d = fa_cout;
                if (cnt_q == CNT_LAST) begin
                    cout_d      = fa_cout;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
`ifdef SERIAL_ADD_FLAGS_EN
                    z_d         = (s_shift == '0);
                    v_d         = carry_q ^ fa_cout;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            a_sr_q      <= '0;
            b_sr_q      <= '0;
            s_q         <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef SERIAL_ADD_FLAGS_EN
            z_q         <= 1'b0;
            v_q         <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_sr_q      <= a_sr_d;
            b_sr_q      <= b_sr_d;
            s_q         <= s_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            cout_q      <= cout_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef SERIAL_ADD_FLAGS_EN
            z_q         <= z_d;
            v_q         <= v_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign S         = s_q;
    assign Cout      = cout_q;
`ifdef SERIAL_ADD_FLAGS_EN
    assign Z         = z_q;
    assign V         = v_q;
`endif

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed, table-driven bench for serial_add_sub (WIDTH=4), plus hand-written
// sequences for backpressure, mid-operation reset and back-to-back operation.
module tb_serial_add_sub;
    import alu_pkg::*;

    localparam int WIDTH = 4;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             sub;
        logic [WIDTH-1:0] s;
        logic             cout;
        logic             z;
        logic             v;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] A = '0;
    logic [WIDTH-1:0] B = '0;
    logic             sub = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] S;
    logic             Cout;
`ifdef SERIAL_ADD_FLAGS_EN
    logic             z_o;
    logic             v_o;
`endif

    int checks   = 0;
    int failures = 0;
    vec_t vecs[9];

    serial_add_sub #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .Cout      (Cout)
`ifdef SERIAL_ADD_FLAGS_EN
        ,
        .Z         (z_o),
        .V         (v_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents operands, waits for the accept edge, then counts cycles until out_valid.
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic s, output int lat);
        int n;
        A        = a;
        B        = b;
        sub      = s;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) checkOutput("accept_timeout", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
    endtask

    task automatic releaseResult();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("release_out_valid", 32'(out_valid), 32'd0);
        checkOutput("release_in_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic checkResult(input string tag, input vec_t v);
        checkOutput({tag, "_S"}, 32'(S), 32'(v.s));
        checkOutput({tag, "_Cout"}, 32'(Cout), 32'(v.cout));
`ifdef SERIAL_ADD_FLAGS_EN
        checkOutput({tag, "_Z"}, 32'(z_o), 32'(v.z));
        checkOutput({tag, "_V"}, 32'(v_o), 32'(v.v));
`endif
    endtask

    initial begin
        int   lat;
        int   n;
        vec_t bp;
        vec_t rr;
        vec_t bb1;
        vec_t bb2;

        //          a      b     sub     s        cout  z     v
        vecs[0] = '{4'd3,  4'd5, OP_ADD, 4'b1000, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{4'd15, 4'd1, OP_ADD, 4'b0000, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{4'd2,  4'd5, OP_SUB, 4'b1101, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{4'd8,  4'd1, OP_SUB, 4'b0111, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{4'd6,  4'd7, OP_ADD, 4'b1101, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{4'd5,  4'd5, OP_SUB, 4'b0000, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{4'd7,  4'd1, OP_ADD, 4'b1000, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{4'd0,  4'd0, OP_ADD, 4'b0000, 1'b0, 1'b1, 1'b0};
        vecs[8] = '{4'd0,  4'd1, OP_SUB, 4'b1111, 1'b0, 1'b0, 1'b0};
        bp  = '{4'd4, 4'd9, OP_ADD, 4'b1101, 1'b0, 1'b0, 1'b0};
        rr  = '{4'd6, 4'd7, OP_ADD, 4'b1101, 1'b0, 1'b0, 1'b1};
        bb1 = '{4'd2, 4'd3, OP_ADD, 4'b0101, 1'b0, 1'b0, 1'b0};
        bb2 = '{4'd9, 4'd4, OP_SUB, 4'b0101, 1'b1, 1'b0, 1'b1};

        // Reset state
        #12;
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_S", 32'(S), 32'd0);
        checkOutput("reset_Cout", 32'(Cout), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Table-driven vectors
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].sub, lat);
            checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'(WIDTH));
            checkResult($sformatf("vec%0d", i), vecs[i]);
            releaseResult();
            tick();
        end

        // Backpressure: hold result for 3 cycles while new operands are offered
        applyStimulus(bp.a, bp.b, bp.sub, lat);
        checkOutput("bp_latency", 32'(lat), 32'(WIDTH));
        A        = 4'd1;
        B        = 4'd1;
        sub      = OP_ADD;
        in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checkOutput($sformatf("bp%0d_out_valid", c), 32'(out_valid), 32'd1);
            checkOutput($sformatf("bp%0d_in_ready", c), 32'(in_ready), 32'd0);
            checkResult($sformatf("bp%0d", c), bp);
        end
        in_valid = 1'b0;
        releaseResult();
        tick();
        checkOutput("bp_no_stray_result", 32'(out_valid), 32'd0);

        // Reset mid-SHIFT after two shift edges
        A        = 4'd15;
        B        = 4'd15;
        sub      = OP_ADD;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_S", 32'(S), 32'd0);
        checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("midrst_Cout", 32'(Cout), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        applyStimulus(rr.a, rr.b, rr.sub, lat);
        checkOutput("midrst_recover_latency", 32'(lat), 32'(WIDTH));
        checkResult("midrst_recover", rr);
        releaseResult();

        // Back-to-back with out_ready tied high and in_valid held
        out_ready = 1'b1;
        A         = bb1.a;
        B         = bb1.b;
        sub       = bb1.sub;
        in_valid  = 1'b1;
        tick();
        checkOutput("b2b_first_accept", 32'(in_ready), 32'd0);
        lat = 0;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
        checkOutput("b2b_first_latency", 32'(lat), 32'(WIDTH));
        checkResult("b2b_first", bb1);
        A   = bb2.a;
        B   = bb2.b;
        sub = bb2.sub;
        tick();
        checkOutput("b2b_handshake_out_valid", 32'(out_valid), 32'd0);
        checkOutput("b2b_handshake_in_ready", 32'(in_ready), 32'd1);
        tick();
        checkOutput("b2b_second_accept", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        checkOutput("b2b_second_latency", 32'(n), 32'(WIDTH));
        checkResult("b2b_second", bb2);
        tick();
        out_ready = 1'b0;
        checkOutput("b2b_end_in_ready", 32'(in_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
